// File: rtl/sigma_delta_dac_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_dac_mc_if
// Purpose  : Sample-frame handshake bundle for sigma_delta_dac_mc.
//            The mixer drives a packed frame with VALID. The DAC answers
//            with READY while its pending buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
interface sigma_delta_dac_mc_if #(
    parameter int MSBI     = 15,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*(MSBI+1)-1:0] DACin;
    logic                         SAMPLE_VALID;
    logic                         SAMPLE_READY;

    modport master (output DACin, output SAMPLE_VALID, input  SAMPLE_READY);
    modport slave  (input  DACin, input  SAMPLE_VALID, output SAMPLE_READY);
endinterface
`default_nettype wire

// File: rtl/sigma_delta_dac_mc.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_dac_mc
// Purpose  : Multi-channel first-order sigma-delta DAC with a double-buffered
//            sample handshake and a click-free soft mute. The soft mute ramps
//            every channel to midscale.
//            Optional: define SDDAC_DITHER_EN to add LFSR dither on the
//            accumulator LSB. Dither breaks up idle tones.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_delta_dac_mc #(
    parameter int MSBI      = 15,
    parameter int CHANNELS  = 2,
    parameter int SIGNED_IN = 0,
    parameter int RAMP_STEP = 16
) (
    input  wire logic                CLK,
    input  wire logic                RESET,
    input  wire logic                CEN,
    sigma_delta_dac_mc_if.slave      smp,
    input  wire logic                MUTE,
    output logic                     MUTED,
    output logic [CHANNELS-1:0]      DACout
);
    localparam int            W      = MSBI + 1;
    localparam logic [MSBI:0] c_MID  = {1'b1, {MSBI{1'b0}}};
    localparam logic [MSBI:0] c_STEP = W'(RAMP_STEP);
    localparam logic [MSBI:0] c_CONV = (SIGNED_IN != 0) ? c_MID : {W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RAMP_DN = 2'd1,
        ST_MUTED   = 2'd2,
        ST_RAMP_UP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pending_full;
    logic                w_accept;
    logic                w_transfer;
    logic [CHANNELS-1:0] w_at_mid;
    logic [CHANNELS-1:0] w_at_held;

    // The pending buffer can only be written while it is empty, so accept and
    // transfer are mutually exclusive by construction.
    assign w_accept         = smp.SAMPLE_VALID & ~r_pending_full;
    assign w_transfer       = CEN & r_pending_full;
    assign smp.SAMPLE_READY = ~r_pending_full;
    assign MUTED            = (r_state == ST_MUTED);

`ifdef SDDAC_DITHER_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, advancing once per modulator tick
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_lfsr <= 16'hACE1;
        else if (CEN)
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
`endif

    // Pending-buffer occupancy flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_pending_full <= 1'b0;
        else if (w_accept)
            r_pending_full <= 1'b1;
        else if (w_transfer)
            r_pending_full <= 1'b0;
    end

    // Mute state register, advancing on modulator ticks only
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= ST_RUN;
        else if (CEN)
            r_state <= w_state_nxt;
    end

    // Mute next-state: a MUTE change always wins over ramp completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:     if (MUTE) w_state_nxt = ST_RAMP_DN;
            ST_RAMP_DN: if (!MUTE) w_state_nxt = ST_RAMP_UP;
                        else if (&w_at_mid) w_state_nxt = ST_MUTED;
            ST_MUTED:   if (!MUTE) w_state_nxt = ST_RAMP_UP;
            ST_RAMP_UP: if (MUTE) w_state_nxt = ST_RAMP_DN;
                        else if (&w_at_held) w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [MSBI:0]   r_pending;
        logic [MSBI:0]   r_held;
        logic [MSBI:0]   r_eff;
        logic [MSBI:0]   r_acc;
        logic            r_dac;
        logic [MSBI:0]   w_target;
        logic [MSBI:0]   w_eff_nxt;
        logic [MSBI:0]   w_acc_in;
        logic [MSBI+1:0] w_sum;

        // Signed input is mapped to excess-midscale by flipping the MSB.
        // Any muting activity overrides the held sample with midscale.
        assign w_target = ((r_state != ST_RUN) || MUTE) ? c_MID : r_held;

`ifdef SDDAC_DITHER_EN
        assign w_acc_in = r_acc ^ {{MSBI{1'b0}}, r_lfsr[c % 16]};
`else
        assign w_acc_in = r_acc;
`endif
        assign w_sum        = {1'b0, w_acc_in} + {1'b0, r_eff};
        assign w_at_mid[c]  = (r_eff == c_MID);
        assign w_at_held[c] = (r_eff == r_held);
        assign DACout[c]    = r_dac;

        // Slew-limited approach to target; snaps once within one step
        always_comb begin
            w_eff_nxt = w_target;
            if (w_target >= r_eff) begin
                if ((w_target - r_eff) > c_STEP)
                    w_eff_nxt = r_eff + c_STEP;
            end else begin
                if ((r_eff - w_target) > c_STEP)
                    w_eff_nxt = r_eff - c_STEP;
            end
        end

        // Per-channel sample buffers, effective value and modulator
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                r_pending <= '0;
                r_held    <= c_MID;
                r_eff     <= c_MID;
                r_acc     <= '0;
                r_dac     <= 1'b0;
            end else begin
                if (w_accept)
                    r_pending <= smp.DACin[c*W +: W] ^ c_CONV;
                if (CEN) begin
                    if (r_pending_full)
                        r_held <= r_pending;
                    r_eff <= w_eff_nxt;
                    r_acc <= w_sum[MSBI:0];
                    r_dac <= w_sum[MSBI+1];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_dac_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sigma_delta_dac_mc
// Purpose  : Scoreboard bench for sigma_delta_dac_mc. A behavioural model
//            queues the expected outputs for every clock. A monitor pops
//            the queue and compares it against the DUT. Directed checks
//            cover reset, density, handshake and mute timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_dac_mc;
    localparam int MSBI   = 15;
    localparam int CH     = 2;
    localparam int STEP   = 16;
    localparam int SIGNED = 0;
    localparam int W      = MSBI + 1;
    localparam int MID    = 1 << MSBI;
    localparam int FULL   = 1 << (MSBI + 1);

    localparam int M_RUN = 0, M_DOWN = 1, M_MUTED = 2, M_UP = 3;

    logic          CLK   = 1'b0;
    logic          RESET = 1'b1;
    logic          CEN   = 1'b0;
    logic          MUTE  = 1'b0;
    logic          MUTED;
    logic [CH-1:0] DACout;

    sigma_delta_dac_mc_if #(.MSBI(MSBI), .CHANNELS(CH)) bus ();

    sigma_delta_dac_mc #(
        .MSBI(MSBI), .CHANNELS(CH), .SIGNED_IN(SIGNED), .RAMP_STEP(STEP)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CEN(CEN), .smp(bus.slave),
        .MUTE(MUTE), .MUTED(MUTED), .DACout(DACout)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CH-1:0] dac;
        logic          rdy;
        logic          mtd;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_eff [CH];
    int            m_held[CH];
    int            m_pend[CH];
    int            m_acc [CH];
    bit            m_pfull;
    int            m_st;
    logic [CH-1:0] m_dac;

    initial begin
        forever begin
            @(posedge CLK);
            if (RESET) begin
                for (int c = 0; c < CH; c++) begin
                    m_eff[c] = MID; m_held[c] = MID; m_pend[c] = 0; m_acc[c] = 0;
                end
                m_dac = '0; m_pfull = 0; m_st = M_RUN;
            end else begin
                bit take;
                take = bus.SAMPLE_VALID && !m_pfull;
                if (CEN) begin
                    bit all_mid, all_held;
                    all_mid = 1; all_held = 1;
                    for (int c = 0; c < CH; c++) begin
                        if (m_eff[c] != MID) all_mid = 0;
                        if (m_eff[c] != m_held[c]) all_held = 0;
                    end
                    for (int c = 0; c < CH; c++) begin
                        int tgt, d, s;
                        s = m_acc[c] + m_eff[c];
                        m_dac[c] = (s >= FULL);
                        m_acc[c] = s % FULL;
                        tgt = (m_st != M_RUN || MUTE) ? MID : m_held[c];
                        d = tgt - m_eff[c];
                        if (d <= STEP && d >= -STEP) m_eff[c] = tgt;
                        else if (d > 0)              m_eff[c] = m_eff[c] + STEP;
                        else                         m_eff[c] = m_eff[c] - STEP;
                    end
                    if (m_pfull) begin
                        for (int c = 0; c < CH; c++) m_held[c] = m_pend[c];
                        m_pfull = 0;
                    end
                    case (m_st)
                        M_RUN:   if (MUTE) m_st = M_DOWN;
                        M_DOWN:  if (!MUTE) m_st = M_UP; else if (all_mid) m_st = M_MUTED;
                        M_MUTED: if (!MUTE) m_st = M_UP;
                        default: if (MUTE) m_st = M_DOWN; else if (all_held) m_st = M_RUN;
                    endcase
                end
                if (take) begin
                    for (int c = 0; c < CH; c++) begin
                        int v;
                        v = int'(bus.DACin[c*W +: W]);
                        m_pend[c] = (SIGNED != 0) ? (v ^ MID) : v;
                    end
                    m_pfull = 1;
                end
            end
            sb.push_back('{dac: m_dac, rdy: !m_pfull, mtd: (m_st == M_MUTED)});
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge CLK);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("mon_dacout", 32'(DACout), 32'(e.dac));
                chk("mon_ready",  32'(bus.SAMPLE_READY), 32'(e.rdy));
                chk("mon_muted",  32'(MUTED), 32'(e.mtd));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [CH*W-1:0] d);
        bit done;
        done = 0;
        bus.DACin = d;
        bus.SAMPLE_VALID = 1'b1;
        for (int k = 0; k < 5000 && !done; k++) begin
            if (bus.SAMPLE_READY) begin
                @(posedge CLK);
                done = 1;
            end
            @(negedge CLK);
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        bus.SAMPLE_VALID = 1'b0;
    endtask

    initial begin
        int ones0, ones1, n;
        bus.DACin = '0;
        bus.SAMPLE_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_ready",  32'(bus.SAMPLE_READY), 32'd1);
        chk("reset_muted",  32'(MUTED), 32'd0);
        chk("reset_dacout", 32'(DACout), 32'd0);

        // Idle midscale toggles 0,1,0,1 on every channel
        RESET = 1'b0;
        CEN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("idle_alternate", 32'(DACout), (i % 2) ? 32'h3 : 32'h0);
        end

        // Frame accept: READY low for one cycle, back after the next tick
        @(negedge CLK);
        bus.DACin = {16'h4000, 16'hC000};
        bus.SAMPLE_VALID = 1'b1;
        @(posedge CLK); #1;
        chk("ready_drop", 32'(bus.SAMPLE_READY), 32'd0);
        @(negedge CLK);
        bus.SAMPLE_VALID = 1'b0;
        @(posedge CLK); #1;
        chk("ready_return", 32'(bus.SAMPLE_READY), 32'd1);

        // Density after the ramp from midscale settles
        repeat (1100) @(negedge CLK);
        ones0 = 0; ones1 = 0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge CLK); #1;
            ones0 += int'(DACout[0]);
            ones1 += int'(DACout[1]);
        end
        chk("density_ch0", 32'(ones0), 32'd768);
        chk("density_ch1", 32'(ones1), 32'd256);

        // Handshake with CEN low: second frame waits for a tick
        @(negedge CLK);
        CEN = 1'b0;
        bus.DACin = {16'h1234, 16'hABCD};
        bus.SAMPLE_VALID = 1'b1;
        @(negedge CLK);
        bus.DACin = {16'h2000, 16'hE000};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("ready_hold_cen0", 32'(bus.SAMPLE_READY), 32'd0);
        end
        CEN = 1'b1;
        @(negedge CLK);
        CEN = 1'b0;
        chk("ready_after_tick", 32'(bus.SAMPLE_READY), 32'd1);
        @(negedge CLK);
        chk("second_frame_taken", 32'(bus.SAMPLE_READY), 32'd0);
        bus.SAMPLE_VALID = 1'b0;
        CEN = 1'b1;

        // Full-scale mute ramp: midscale after 2048 ticks, MUTED one later
        @(negedge CLK);
        send({16'hFFFF, 16'hFFFF});
        repeat (4000) @(negedge CLK);
        MUTE = 1'b1;
        n = 0;
        for (int k = 0; k < 3000 && !MUTED; k++) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("mute_ticks", 32'(n), 32'd2049);
        @(negedge CLK);
        MUTE = 1'b0;
        repeat (2200) @(negedge CLK);

        // Reverse the mute mid-ramp
        MUTE = 1'b1;
        repeat (100) @(negedge CLK);
        MUTE = 1'b0;
        repeat (300) @(negedge CLK);

        // Asynchronous reset mid-ramp with a frame pending
        MUTE = 1'b1;
        repeat (50) @(negedge CLK);
        CEN = 1'b0;
        send({16'h0F00, 16'h7777});
        RESET = 1'b1;
        #1;
        chk("async_reset_dacout", 32'(DACout), 32'd0);
        chk("async_reset_ready",  32'(bus.SAMPLE_READY), 32'd1);
        chk("async_reset_muted",  32'(MUTED), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        MUTE = 1'b0;
        CEN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            chk("post_reset_alternate", 32'(DACout), (i % 2) ? 32'h3 : 32'h0);
        end

        // Randomized traffic, CEN gaps and mute toggles
        for (int i = 0; i < 6000; i++) begin
            @(negedge CLK);
            CEN = ($urandom_range(0, 3) != 0);
            bus.SAMPLE_VALID = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       bus.DACin = {CH{16'hFFFF}};
                1:       bus.DACin = '0;
                default: bus.DACin = {16'($urandom), 16'($urandom)};
            endcase
            if ($urandom_range(0, 599) == 0) MUTE = ~MUTE;
        end
        @(negedge CLK);
        bus.SAMPLE_VALID = 1'b0;
        repeat (3) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
